// File: rtl/stack_pkg.sv
// Shared command encoding and modulo pointer arithmetic for the parametrised LIFO stack.
package stack_pkg;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_PUSH = 2'b01,
        CMD_POP  = 2'b10,
        CMD_GET  = 2'b11
    } stack_cmd_e;

    // (a - b) mod depth, valid for a in [0, depth) and b in [0, depth].
    function automatic int unsigned wrap_sub(int unsigned a, int unsigned b, int unsigned depth);
        return (a >= b) ? (a - b) : (a + depth - b);
    endfunction

endpackage

// File: rtl/stack_ptr_ctrl.sv
// Stack pointer/occupancy tracking and command decode into memory write/read strobes.
// Full-stack PUSH overwrites the oldest entry when STACK_WRAP_EN is defined, else it is rejected.
module stack_ptr_ctrl
    import stack_pkg::*;
#(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  stack_cmd_e       cmd,
    input  logic [IDX_W-1:0] index,
    output logic             wr_en,
    output logic [IDX_W-1:0] wr_addr,
    output logic             rd_en,
    output logic [IDX_W-1:0] rd_addr,
    output logic             err,
    output logic [IDX_W:0]   count
);

    localparam logic [IDX_W:0] DEPTH_W = (IDX_W + 1)'(DEPTH);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W:0]   count_q, count_d;
    logic [IDX_W:0]   inc_w;
    logic [IDX_W:0]   get_off;
    logic [IDX_W-1:0] ptr_inc, ptr_dec, get_addr;
    logic             full, empty, idx_ok;

    assign full    = (count_q == DEPTH_W);
    assign empty   = (count_q == '0);
    assign wr_addr = ptr_q;
    assign count   = count_q;

    // Address arithmetic stays in range for non-power-of-two DEPTH.
    always_comb begin
        inc_w    = {1'b0, ptr_q} + (IDX_W + 1)'(1);
        ptr_inc  = (inc_w >= DEPTH_W) ? IDX_W'(inc_w - DEPTH_W) : inc_w[IDX_W-1:0];
        ptr_dec  = IDX_W'(wrap_sub(32'(ptr_q), 32'd1, DEPTH));
        get_off  = {1'b0, index} + (IDX_W + 1)'(1);
        get_addr = IDX_W'(wrap_sub(32'(ptr_q), 32'(get_off), DEPTH));
        idx_ok   = ({1'b0, index} < count_q);
    end

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err     = 1'b0;
        rd_addr = ptr_dec;
        unique case (cmd)
            CMD_NOP: begin
            end
            CMD_PUSH: begin
                if (!full) begin
                    wr_en   = 1'b1;
                    ptr_d   = ptr_inc;
                    count_d = count_q + (IDX_W + 1)'(1);
                end else begin
`ifdef STACK_WRAP_EN
                    wr_en = 1'b1;
                    ptr_d = ptr_inc;
`else
                    err = 1'b1;
`endif
                end
            end
            CMD_POP: begin
                if (!empty) begin
                    rd_en   = 1'b1;
                    rd_addr = ptr_dec;
                    ptr_d   = ptr_dec;
                    count_d = count_q - (IDX_W + 1)'(1);
                end else begin
                    err = 1'b1;
                end
            end
            CMD_GET: begin
                if (idx_ok) begin
                    rd_en   = 1'b1;
                    rd_addr = get_addr;
                end else begin
                    err = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/stack_param.sv
// Parametrised LIFO stack with push/pop/indexed-get; holds the storage and registered outputs.
// Optional macro STACK_WRAP_EN makes a full-stack PUSH overwrite the oldest entry.
module stack_param
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 5,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [1:0]       COMMAND,
    input  logic [IDX_W-1:0] INDEX,
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] DOUT,
    output logic             DOUT_VALID,
    output logic             ERR,
    output logic             FULL,
    output logic             EMPTY,
    output logic [IDX_W:0]   COUNT
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic             rd_en;
    logic [IDX_W-1:0] rd_addr;
    logic             err_c;
    logic [IDX_W:0]   count;

    stack_ptr_ctrl #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ptr_ctrl (
        .clk     (CLK),
        .rst     (RESET),
        .cmd     (stack_cmd_e'(COMMAND)),
        .index   (INDEX),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .err     (err_c),
        .count   (count)
    );

    // Flags decode only from registered occupancy.
    assign COUNT = count;
    assign FULL  = (count == (IDX_W + 1)'(DEPTH));
    assign EMPTY = (count == '0);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            DOUT       <= '0;
            DOUT_VALID <= 1'b0;
            ERR        <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_addr] <= DIN;
            end
            if (rd_en) begin
                DOUT <= mem[rd_addr];
            end
            DOUT_VALID <= rd_en;
            ERR        <= err_c;
        end
    end

endmodule
